// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and walks it through a req/gnt/rvalid
// instruction port. Redirects (trap over branch) retarget the PC at any point;
// a fetch already in flight when a redirect lands is marked to be discarded.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h80000000,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_instr, w_instr_n;
    logic [31:0] r_instr_pc, w_instr_pc_n;
    logic        r_kill, w_kill_n;
    logic        r_valid, w_valid_n;

    logic        w_event;
    logic [31:0] w_target;

    // Trap wins over branch; targets are always word aligned.
    assign w_event  = trap_i | redirect_i;
    assign w_target = {(trap_i ? trap_pc_i[31:2] : redirect_pc_i[31:2]), 2'b00};

    assign instr_req_o   = (r_state == S_REQ);
    assign instr_addr_o  = r_pc;
    assign pc_o          = r_pc;
    assign instr_valid_o = r_valid;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;

    // Next state, next PC and held-instruction updates.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_instr_n    = r_instr;
        w_instr_pc_n = r_instr_pc;
        w_kill_n     = r_kill;
        w_valid_n    = r_valid;
        case (r_state)
            S_BOOT: begin
                w_state_n = S_REQ;
                if (w_event) w_pc_n = w_target;
            end
            S_REQ: begin
                if (instr_gnt_i) begin
                    w_state_n = S_WAIT;
                    // Granted fetch is for the old PC; drop its response.
                    if (w_event) begin
                        w_pc_n   = w_target;
                        w_kill_n = 1'b1;
                    end
                end else if (w_event) begin
                    w_pc_n = w_target;
                end
            end
            S_WAIT: begin
                if (instr_rvalid_i) begin
                    if (r_kill || w_event) begin
                        w_kill_n  = 1'b0;
                        w_state_n = S_REQ;
                        if (w_event) w_pc_n = w_target;
                    end else begin
                        w_instr_n    = instr_rdata_i;
                        w_instr_pc_n = r_pc;
                        w_valid_n    = 1'b1;
                        w_pc_n       = r_pc + 32'd4;
                        w_state_n    = S_HOLD;
                    end
                end else if (w_event) begin
                    w_pc_n   = w_target;
                    w_kill_n = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect drops the held instruction even under stall.
                if (w_event || !stall_i) begin
                    w_valid_n = 1'b0;
                    w_instr_n = NOP_INSTR;
                    w_state_n = S_REQ;
                    if (w_event) w_pc_n = w_target;
                end
            end
            default: w_state_n = S_BOOT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= RESET_VECTOR;
            r_kill     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_instr    <= w_instr_n;
            r_instr_pc <= w_instr_pc_n;
            r_kill     <= w_kill_n;
            r_valid    <= w_valid_n;
        end
    end

endmodule
